// File: rtl/seq_multiplier_pkg.sv
// mult_pkg: shared state encoding, default width and counter sizing for seq_multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;
    localparam int DEFAULT_WORD_LENGTH = 16;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/done handshake, operands and signed product of seq_multiplier
interface seq_multiplier_if import mult_pkg::*; #(parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH);
    logic                       start;
    logic [WORD_LENGTH-1:0]     multiplicand;
    logic [WORD_LENGTH-1:0]     multiplier;
    logic [2*WORD_LENGTH-1:0]   product;
    logic                       sign;
    logic                       busy;
    logic                       done;
    modport master(output start, multiplicand, multiplier, input product, sign, busy, done);
    modport slave(input start, multiplicand, multiplier, output product, sign, busy, done);
endinterface

// File: rtl/seq_multiplier_abs.sv
// abs_sign_unit: two's-complement operand to unsigned magnitude plus sign bit
module abs_sign_unit #(parameter int W = 16) (
    input  logic [W-1:0] x,
    output logic [W-1:0] mag,
    output logic         neg
);
    assign neg = x[W-1];
    assign mag = neg ? ~x + 1'b1 : x;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: signed shift-add multiplier, one bit per cycle; SEQ_MULT_EARLY_TERMINATE_EN stops once the multiplier runs out of set bits
module seq_multiplier import mult_pkg::*; #(parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH) (
    input logic             clk,
    input logic             reset,
    seq_multiplier_if.slave bus
);
    localparam int W  = WORD_LENGTH;
    localparam int CW = cnt_width(W);
    mult_state_t   state, state_n;
    logic [2*W-1:0] mcand, acc, product_q;
    logic [W-1:0]   mreg, mag_a, mag_b;
    logic [CW-1:0]  cnt;
    logic           neg, sign_q, neg_a, neg_b, last;
    abs_sign_unit #(.W(W)) u_abs_a (.x(bus.multiplicand), .mag(mag_a), .neg(neg_a));
    abs_sign_unit #(.W(W)) u_abs_b (.x(bus.multiplier), .mag(mag_b), .neg(neg_b));
    assign bus.product = product_q;
    assign bus.sign    = sign_q;
    assign bus.busy    = (state == RUN) || (state == FIX);
    assign bus.done    = state == DONE;
`ifdef SEQ_MULT_EARLY_TERMINATE_EN
    // leave RUN on the edge that shifts out the last set multiplier bit
    assign last = (cnt == CW'(W - 1)) || (mreg[W-1:1] == '0);
`else
    assign last = cnt == CW'(W - 1);
`endif
    always_comb begin
        state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
                  state == RUN  ? (last ? FIX : RUN) :
                  state == FIX  ? DONE : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            mreg      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            product_q <= '0;
            sign_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                mcand <= {{W{1'b0}}, mag_a};
                mreg  <= mag_b;
                neg   <= neg_a ^ neg_b;
                acc   <= '0;
                cnt   <= '0;
            end
            if (state == RUN) begin
                if (mreg[0]) acc <= acc + mcand;
                mcand <= mcand << 1;
                mreg  <= mreg >> 1;
                cnt   <= cnt + 1'b1;
            end
            if (state == FIX) begin
                product_q <= neg ? -acc : acc;
                sign_q    <= neg && (acc != '0);
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and reference-checked vectors for seq_multiplier
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    seq_multiplier_if #(.WORD_LENGTH(16)) bus();
    seq_multiplier #(.WORD_LENGTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // edges counted from the accept edge (inclusive) to the done-high cycle
    function automatic int exp_lat(input logic [15:0] b);
        logic [15:0] m;
        int h;
        m = b[15] ? ~b + 16'd1 : b;
        h = 15;
`ifdef SEQ_MULT_EARLY_TERMINATE_EN
        h = 0;
        for (int i = 0; i < 16; i++) if (m[i]) h = i;
`endif
        return h + 3;
    endfunction

    task automatic mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_p, input logic exp_s);
        int n;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat(b)));
        chk({tag, "_prod"}, 64'(bus.product), 64'(exp_p));
        chk({tag, "_sign"}, 64'(bus.sign), 64'(exp_s));
        tick();
        chk({tag, "_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] got;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        tick();
        tick();
        chk("rst_prod", 64'(bus.product), 64'd0);
        chk("rst_flags", 64'({bus.sign, bus.busy, bus.done}), 64'd0);
        reset = 1'b1;
        tick();
        mul("p3x5", 16'd3, 16'd5, 32'h0000000F, 1'b0);
        mul("m7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6, 1'b1);
        mul("minxmin", 16'h8000, 16'h8000, 32'h40000000, 1'b0);
        mul("minx1", 16'h8000, 16'd1, 32'hFFFF8000, 1'b1);
        mul("zxm5", 16'd0, 16'hFFFB, 32'h00000000, 1'b0);
        mul("maxxmax", 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0);
        mul("p100x1", 16'd100, 16'd1, 32'd100, 1'b0);
        mul("p100xmin", 16'd100, 16'h8000, 32'hFFCE0000, 1'b1);
        // start retriggers and operand churn during RUN must not disturb the result
        bus.multiplicand = 16'd3;
        bus.multiplier   = 16'd5;
        bus.start        = 1'b1;
        tick();
        dones = 0;
        got = '0;
        for (int i = 1; i <= 25; i++) begin
            bus.start = (i == 3) || (i == 10);
            bus.multiplicand = 16'($urandom);
            bus.multiplier   = 16'($urandom);
            tick();
            if (bus.done) begin
                dones++;
                got = bus.product;
            end
        end
        bus.start = 1'b0;
        chk("ign_prod", 64'(got), 64'h0000000F);
        chk("ign_dones", 64'(dones), 64'd1);
        // reset mid-operation
        bus.multiplicand = 16'h7FFF;
        bus.multiplier   = 16'h7FFF;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_prod", 64'(bus.product), 64'd0);
        chk("mrst_flags", 64'({bus.sign, bus.busy, bus.done}), 64'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("mrst_nodone", 64'(dones), 64'd0);
        mul("after_rst", 16'd2, 16'hFFFD, 32'hFFFFFFFA, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            longint r;
            a = 16'($urandom);
            b = 16'($urandom);
            r = longint'($signed(a)) * longint'($signed(b));
            mul("rand", a, b, 32'(r), r < 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
